// File: rtl/kbd_input_fifo.sv
`default_nettype none
// ============================================================================
// Module   : kbd_input_fifo
// Brief    : LC-3 keyboard controller with a type-ahead FIFO that serves KBSR/KBDR
// Revision : 1.0 - initial release
// ============================================================================
module kbd_input_fifo #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int HOLDOFF_CYC = 1,
    parameter bit OVERWRITE   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ext_valid,
    input  logic [DATA_W-1:0]       ext_data,
    output logic                    ext_ready,
    input  logic                    ld_kbsr,
    input  logic [15:0]             kbsr_wdata,
    input  logic                    rd_kbdr,
    output logic [15:0]             kbsr,
    output logic [15:0]             kbdr,
    output logic                    int_req,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int             AW        = $clog2(DEPTH);
    localparam int             CW        = AW + 1;
    localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);
    localparam logic [3:0]     HOLD_LOAD = 4'(HOLDOFF_CYC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMMIT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   stage;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [3:0]          hold_cnt;
    logic                ie;
    logic                ovf;
    logic                accept;
    logic                pop;
    logic                commit;
    logic                full;
    logic                drop;
    logic                not_empty;
    logic [15:0]         head_ext;
    logic                unused_wdata;

    assign not_empty = (count != '0);
    assign full      = (count == FULL_CNT);
    assign pop       = rd_kbdr & not_empty;
    assign commit    = (state == COMMIT);
    // A concurrent pop frees the slot, so the commit only evicts when nobody reads.
    assign drop      = commit & full & ~pop & OVERWRITE;
    assign accept    = ext_valid & ext_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ext_ready = 1'b0;
        case (state)
            IDLE: begin
                ext_ready = rst_n & (~full | OVERWRITE);
                if (ext_valid && ext_ready) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                state_nxt = (HOLDOFF_CYC > 0) ? HOLDOFF : IDLE;
            end
            HOLDOFF: begin
                if (hold_cnt == 4'd1) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            stage    <= '0;
            hold_cnt <= '0;
            ie       <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (accept) begin
                stage <= ext_data;
            end
            if (commit) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop | drop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (commit & ~pop & ~full) begin
                count <= count + CW'(1);
            end else if (pop & ~commit) begin
                count <= count - CW'(1);
            end
            if (commit) begin
                hold_cnt <= HOLD_LOAD;
            end else if (state == HOLDOFF) begin
                hold_cnt <= hold_cnt - 4'd1;
            end
            if (ld_kbsr) begin
                ie <= kbsr_wdata[14];
            end
            // Overflow set takes priority over a write-1-to-clear in the same cycle.
            if (drop) begin
                ovf <= 1'b1;
            end else if (ld_kbsr & kbsr_wdata[13]) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_ptr] <= stage;
        end
    end

    always_comb begin
        head_ext              = '0;
        head_ext[DATA_W-1:0]  = mem[rd_ptr];
    end

    assign kbdr    = not_empty ? head_ext : 16'h0000;
    assign kbsr    = {not_empty, ie, ovf, 13'b0};
    assign int_req = ie & not_empty;

    assign unused_wdata = ^{kbsr_wdata[15], kbsr_wdata[12:0]};

endmodule
`default_nettype wire

// File: tb/tb_kbd_input_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_kbd_input_fifo
// Brief    : Scoreboard bench for kbd_input_fifo (stall and overwrite variants)
// Revision : 1.0 - initial release
// ============================================================================
module tb_kbd_input_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ev   [2];
    logic [7:0]  ed   [2];
    logic        er   [2];
    logic        ld   [2];
    logic [15:0] wd   [2];
    logic        rd   [2];
    logic [15:0] kbsr [2];
    logic [15:0] kbdr [2];
    logic        irq  [2];
    logic [2:0]  cnt  [2];

    logic [7:0]  sb0 [$];
    logic [7:0]  sb1 [$];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    kbd_input_fifo #(.DATA_W(8), .DEPTH(4), .HOLDOFF_CYC(1), .OVERWRITE(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ext_valid(ev[0]), .ext_data(ed[0]), .ext_ready(er[0]),
        .ld_kbsr(ld[0]), .kbsr_wdata(wd[0]), .rd_kbdr(rd[0]), .kbsr(kbsr[0]),
        .kbdr(kbdr[0]), .int_req(irq[0]), .count(cnt[0])
    );

    kbd_input_fifo #(.DATA_W(8), .DEPTH(4), .HOLDOFF_CYC(0), .OVERWRITE(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ext_valid(ev[1]), .ext_data(ed[1]), .ext_ready(er[1]),
        .ld_kbsr(ld[1]), .kbsr_wdata(wd[1]), .rd_kbdr(rd[1]), .kbsr(kbsr[1]),
        .kbdr(kbdr[1]), .int_req(irq[1]), .count(cnt[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the accepting edge, i.e. during COMMIT.
    task automatic send(input int d, input logic [7:0] c, input bit pop_same);
        int k;
        k = 0;
        ev[d] = 1'b1;
        ed[d] = c;
        while (er[d] !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) begin
            chk("send_ready", {31'b0, er[d]}, 32'd1);
            ev[d] = 1'b0;
            return;
        end
        tick();
        ev[d] = 1'b0;
        if (d == 0) begin
            sb0.push_back(c);
        end else begin
            if (sb1.size() == 4 && !pop_same) sb1.delete(0);
            sb1.push_back(c);
        end
    endtask

    task automatic rd_chk(input int d, input string tag);
        logic [15:0] e;
        e = 16'h0000;
        if (d == 0) begin
            if (sb0.size() > 0) e = {8'h00, sb0.pop_front()};
        end else begin
            if (sb1.size() > 0) e = {8'h00, sb1.pop_front()};
        end
        chk(tag, {16'h0, kbdr[d]}, {16'h0, e});
        rd[d] = 1'b1;
        tick();
        rd[d] = 1'b0;
    endtask

    task automatic ld_wr(input int d, input logic [15:0] v);
        wd[d] = v;
        ld[d] = 1'b1;
        tick();
        ld[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ev[i] = 1'b0; ed[i] = 8'h00; ld[i] = 1'b0; wd[i] = 16'h0; rd[i] = 1'b0;
        end
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", {31'b0, er[i]}, 32'd0);
            chk("rst_kbsr", {16'h0, kbsr[i]}, 32'h0);
            chk("rst_kbdr", {16'h0, kbdr[i]}, 32'h0);
            chk("rst_irq", {31'b0, irq[i]}, 32'd0);
            chk("rst_cnt", {29'b0, cnt[i]}, 32'd0);
        end
        rst_n = 1'b1;
        tick();

        // Single character latency, holdoff of one cycle
        ev[0] = 1'b1; ed[0] = 8'h41;
        chk("idle_ready", {31'b0, er[0]}, 32'd1);
        tick();
        ev[0] = 1'b0;
        sb0.push_back(8'h41);
        chk("commit_ready", {31'b0, er[0]}, 32'd0);
        chk("kbsr_pre", {16'h0, kbsr[0]}, 32'h0);
        tick();
        chk("hold_ready", {31'b0, er[0]}, 32'd0);
        chk("kbsr_post", {16'h0, kbsr[0]}, 32'h8000);
        chk("kbdr_post", {16'h0, kbdr[0]}, 32'h0041);
        chk("cnt_one", {29'b0, cnt[0]}, 32'd1);
        tick();
        chk("ready_back", {31'b0, er[0]}, 32'd1);
        rd_chk(0, "rd_41");

        // Interrupt enable
        ld_wr(0, 16'h4000);
        chk("ie_kbsr", {16'h0, kbsr[0]}, 32'h4000);
        chk("ie_irq_empty", {31'b0, irq[0]}, 32'd0);
        send(0, 8'h42, 1'b0);
        chk("irq_pre", {31'b0, irq[0]}, 32'd0);
        tick();
        chk("irq_kbsr", {16'h0, kbsr[0]}, 32'hC000);
        chk("irq_up", {31'b0, irq[0]}, 32'd1);
        rd_chk(0, "rd_42");
        chk("irq_kbsr_after", {16'h0, kbsr[0]}, 32'h4000);
        chk("irq_down", {31'b0, irq[0]}, 32'd0);
        chk("irq_cnt", {29'b0, cnt[0]}, 32'd0);

        // Stall policy when full
        for (int i = 0; i < 4; i++) send(0, 8'(8'h31 + i), 1'b0);
        tick();
        tick();
        chk("full_cnt", {29'b0, cnt[0]}, 32'd4);
        ev[0] = 1'b1; ed[0] = 8'h35;
        for (int i = 0; i < 3; i++) begin
            chk("full_stall", {31'b0, er[0]}, 32'd0);
            tick();
        end
        rd_chk(0, "rd_31");
        send(0, 8'h35, 1'b0);
        tick();
        tick();
        chk("refill_cnt", {29'b0, cnt[0]}, 32'd4);
        rd_chk(0, "rd_32");
        rd_chk(0, "rd_33");

        // Pop on the commit cycle
        send(0, 8'h36, 1'b1);
        rd_chk(0, "rd_34_commit");
        chk("commit_pop_cnt", {29'b0, cnt[0]}, 32'd2);
        rd_chk(0, "rd_35");
        rd_chk(0, "rd_36");
        rd_chk(0, "rd_empty");
        chk("empty_cnt", {29'b0, cnt[0]}, 32'd0);
        chk("empty_kbdr", {16'h0, kbdr[0]}, 32'h0);
        chk("empty_kbsr", {16'h0, kbsr[0]}, 32'h4000);

        // Reset while a commit is pending
        send(0, 8'h51, 1'b0);
        send(0, 8'h52, 1'b0);
        send(0, 8'h53, 1'b0);
        send(0, 8'h54, 1'b0);
        chk("pre_rst_cnt", {29'b0, cnt[0]}, 32'd3);
        sb0.delete();
        rst_n = 1'b0;
        #1;
        chk("rst_low_ready", {31'b0, er[0]}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("mid_rst_cnt", {29'b0, cnt[0]}, 32'd0);
        chk("mid_rst_kbsr", {16'h0, kbsr[0]}, 32'h0);
        chk("mid_rst_kbdr", {16'h0, kbdr[0]}, 32'h0);
        chk("mid_rst_idle", {31'b0, er[0]}, 32'd1);
        repeat (3) tick();
        chk("staged_gone_cnt", {29'b0, cnt[0]}, 32'd0);
        chk("staged_gone_kbdr", {16'h0, kbdr[0]}, 32'h0);

        // Overwrite policy
        for (int i = 0; i < 5; i++) send(1, 8'(8'h31 + i), 1'b0);
        tick();
        chk("ovw_kbsr", {16'h0, kbsr[1]}, 32'hA000);
        chk("ovw_cnt", {29'b0, cnt[1]}, 32'd4);
        for (int i = 0; i < 4; i++) rd_chk(1, "ovw_rd");
        chk("ovw_kbsr_empty", {16'h0, kbsr[1]}, 32'h2000);
        ld_wr(1, 16'h2000);
        chk("ovw_clear", {16'h0, kbsr[1]}, 32'h0);

        // Overwrite with a concurrent pop must not flag overflow
        for (int i = 0; i < 4; i++) send(1, 8'(8'h61 + i), 1'b0);
        tick();
        send(1, 8'h65, 1'b1);
        rd_chk(1, "ovw_rd_61");
        chk("ovw_pop_cnt", {29'b0, cnt[1]}, 32'd4);
        chk("ovw_pop_kbsr", {16'h0, kbsr[1]}, 32'h8000);
        for (int i = 0; i < 4; i++) rd_chk(1, "ovw_pop_rd");
        chk("ovw_drain_cnt", {29'b0, cnt[1]}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kbd_input_fifo.md
Name: kbd_input_fifo

Overview:
- Parametrised keyboard input controller for the LC-3 memory-mapped keyboard.
- Accepts characters from an external source over a valid/ready handshake, stages and commits them into a DEPTH-entry FIFO, and presents them to the CPU as KBSR/KBDR.
- Adds type-ahead buffering, interrupt request, overflow policy and a post-commit holdoff.
- Sits between the external keyboard source and the memory-mapped I/O mux.

Parameters:
- DATA_W, 8, character width; 1..16; zero-extended into kbdr.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- HOLDOFF_CYC, 1, idle cycles after each commit before the next accept; 0..15.
- OVERWRITE, 0, full policy: 0 = stall source (ext_ready low); 1 = accept and drop the oldest entry.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- ext_valid  input  1  source has a character.
- ext_data  input  DATA_W  character from source.
- ext_ready  output  1  controller can accept this cycle.
- ld_kbsr  input  1  CPU write strobe to KBSR.
- kbsr_wdata  input  16  CPU write data; bit14 = IE, bit13 = write-1-to-clear overflow.
- rd_kbdr  input  1  CPU read strobe of KBDR; pops the FIFO.
- kbsr  output  16  {ready, IE, ovf, 13'b0}.
- kbdr  output  16  zero-extended FIFO head; 16'h0000 when empty.
- int_req  output  1  IE & ready.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; FIFO pointers, count, IE, ovf, staging register and holdoff counter all cleared.
  - kbsr = 0, kbdr = 0, int_req = 0.
  - ext_ready is held 0 while rst_n is low.
  - Reset mid-operation discards any staged character and the FIFO contents.
- FSM states: IDLE, COMMIT, HOLDOFF.
  - IDLE: ext_ready = (count < DEPTH) | OVERWRITE. If ext_valid & ext_ready: latch ext_data into staging, go to COMMIT. Otherwise stay in IDLE.
  - COMMIT: ext_ready = 0. Write staging to tail, advance wr ptr. Go to HOLDOFF if HOLDOFF_CYC > 0 (load counter with HOLDOFF_CYC), else IDLE.
  - HOLDOFF: ext_ready = 0. Decrement counter; go to IDLE on the edge where counter == 1.
- Latency:
  - Character accepted at edge N is written at edge N+1.
  - kbsr[15] and kbdr reflect it after edge N+1 if the FIFO was empty.
  - Max accept rate is one per 2+HOLDOFF_CYC cycles.
- Outputs:
  - kbsr[15] = (count != 0), combinational from registered count.
  - int_req = kbsr[14] & kbsr[15].
- Pop: rd_kbdr with count != 0 advances rd ptr and decrements count at the edge; kbdr shows the current head before that edge. rd_kbdr when empty is ignored.
- Simultaneous COMMIT and pop: both pointers advance; count unchanged.
- Full at COMMIT:
  - OVERWRITE=1: oldest entry is dropped (rd ptr advances), count stays DEPTH, ovf is set.
  - OVERWRITE=1 with a pop in the same cycle: the pop consumes the oldest entry, the new entry is written, and ovf is not set.
  - OVERWRITE=0: COMMIT on full cannot occur, because ext_ready was low in IDLE.
- ld_kbsr:
  - IE <= kbsr_wdata[14].
  - If kbsr_wdata[13] = 1, ovf is cleared, unless an overflow sets it in the same cycle; set wins.
  - Bits 15 and 12:0 are read-only.
- Pointers wrap modulo DEPTH; count saturates at DEPTH by construction.

Test Plan:
- Reset, then send 8'h41 with HOLDOFF_CYC=1 -> ext_ready drops for 2 cycles; kbsr=16'h8000 and kbdr=16'h0041 one edge after accept; count=1.
- Write kbsr_wdata=16'h4000, send 8'h42 -> int_req rises together with kbsr[15]; rd_kbdr -> kbsr=16'h4000, int_req=0, count=0.
- OVERWRITE=0, DEPTH=4, send 8'h31..8'h34 -> count=4, ext_ready=0 with ext_valid held; one rd_kbdr returns 16'h0031, then 8'h35 is accepted.
- OVERWRITE=1, DEPTH=4, send 8'h31..8'h35 -> kbsr[13]=1, count=4, successive reads return 8'h32..8'h35; ld_kbsr with 16'h2000 clears ovf.
- With count=2, assert rd_kbdr on the COMMIT cycle -> count stays 2 and FIFO order is preserved; rd_kbdr on empty -> no change, kbdr=0.
- Pull rst_n low while in COMMIT with count=3 -> next cycle count=0, kbsr=0, state IDLE, staged character never appears.
